// File: rtl/yuv_frame_scanout_sched.sv
// rtl/yuv_frame_scanout_sched.sv - planar YUV 4:2:0 frame scan-out scheduler
module yuv_frame_scanout_sched #(
    parameter int WIDTH  = 352,
    parameter int HEIGHT = 288,
    parameter int BURST  = 16,
    parameter int ADR_W  = 24,
    parameter int DESC_W = 32
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              fifo_valid_i,
    input  logic [DESC_W-1:0] fifo_y_i,
    input  logic [DESC_W-1:0] fifo_u_i,
    input  logic [DESC_W-1:0] fifo_v_i,
    output logic              fifo_strobe_o,
    input  logic              vsync_i,
    input  logic              line_req_i,
    output logic              mem_req_o,
    output logic [ADR_W-1:0]  mem_adr_o,
    output logic [1:0]        mem_plane_o,
    input  logic              mem_ack_i,
    output logic              line_done_o,
    output logic              release_o,
    output logic [DESC_W-1:0] released_y_o,
    output logic [DESC_W-1:0] released_u_o,
    output logic [DESC_W-1:0] released_v_o,
    output logic              has_frame_o,
    output logic [7:0]        repeat_cnt_o,
    output logic              overrun_o
);

    localparam int NY = WIDTH / BURST;
    localparam int NC = WIDTH / (2 * BURST);
    localparam int BW = $clog2(NY + 1);
    localparam int LW = $clog2(HEIGHT + 1);

    localparam logic [ADR_W-1:0] STEP    = ADR_W'(BURST);
    localparam logic [ADR_W-1:0] Y_PITCH = ADR_W'(WIDTH);
    localparam logic [ADR_W-1:0] C_PITCH = ADR_W'(WIDTH / 2);
    localparam logic [BW-1:0]    Y_LAST  = BW'(NY - 1);
    localparam logic [BW-1:0]    C_LAST  = BW'(NC - 1);
    localparam logic [LW-1:0]    LINES   = LW'(HEIGHT);

    localparam logic [1:0] PL_Y = 2'd0;
    localparam logic [1:0] PL_U = 2'd1;
    localparam logic [1:0] PL_V = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        FETCH_Y,
        FETCH_U,
        FETCH_V,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [DESC_W-1:0] cur_y_q, cur_y_d;
    logic [DESC_W-1:0] cur_u_q, cur_u_d;
    logic [DESC_W-1:0] cur_v_q, cur_v_d;
    logic [LW-1:0]     line_q, line_d;
    logic              pending_vs_q, pending_vs_d;
    logic              has_frame_q, has_frame_d;
    logic [7:0]        repeat_cnt_q, repeat_cnt_d;
    logic              overrun_q, overrun_d;
    logic [BW-1:0]     burst_q, burst_d;
    logic              mem_req_q, mem_req_d;
    logic [ADR_W-1:0]  mem_adr_q, mem_adr_d;
    logic [1:0]        mem_plane_q, mem_plane_d;
    logic              release_q, release_d;
    logic [DESC_W-1:0] released_y_q, released_y_d;
    logic [DESC_W-1:0] released_u_q, released_u_d;
    logic [DESC_W-1:0] released_v_q, released_v_d;
    logic              strobe_prev_q;

    logic              service;
    logic              vs_abort;
    logic [ADR_W-1:0]  y_base, u_base, v_base;

    // The strobe_prev_q guard keeps two pops from ever landing on adjacent cycles.
    assign service       = (state_q == IDLE) && pending_vs_q && !strobe_prev_q;
    assign fifo_strobe_o = service && fifo_valid_i;
    assign vs_abort      = pending_vs_q || vsync_i;

    assign y_base = cur_y_q[ADR_W-1:0] + ADR_W'(line_q) * Y_PITCH;
    assign u_base = cur_u_q[ADR_W-1:0] + ADR_W'(line_q >> 1) * C_PITCH;
    assign v_base = cur_v_q[ADR_W-1:0] + ADR_W'(line_q >> 1) * C_PITCH;

    always_comb begin
        state_d      = state_q;
        cur_y_d      = cur_y_q;
        cur_u_d      = cur_u_q;
        cur_v_d      = cur_v_q;
        line_d       = line_q;
        pending_vs_d = vsync_i || (pending_vs_q && !service);
        has_frame_d  = has_frame_q;
        repeat_cnt_d = repeat_cnt_q;
        overrun_d    = overrun_q || (line_req_i && (state_q != IDLE));
        burst_d      = burst_q;
        mem_req_d    = mem_req_q;
        mem_adr_d    = mem_adr_q;
        mem_plane_d  = mem_plane_q;
        release_d    = 1'b0;
        released_y_d = released_y_q;
        released_u_d = released_u_q;
        released_v_d = released_v_q;

        case (state_q)
            IDLE: begin
                if (service) begin
                    if (fifo_valid_i) begin
                        cur_y_d      = fifo_y_i;
                        cur_u_d      = fifo_u_i;
                        cur_v_d      = fifo_v_i;
                        release_d    = has_frame_q;
                        released_y_d = cur_y_q;
                        released_u_d = cur_u_q;
                        released_v_d = cur_v_q;
                        has_frame_d  = 1'b1;
                        repeat_cnt_d = 8'd0;
                    end else if (has_frame_q && (repeat_cnt_q != 8'hFF)) begin
                        repeat_cnt_d = repeat_cnt_q + 8'd1;
                    end
                    line_d = '0;
                end else if (line_req_i && has_frame_q && (line_q < LINES)
                             && !pending_vs_q && !vsync_i) begin
                    state_d     = FETCH_Y;
                    mem_req_d   = 1'b1;
                    mem_adr_d   = y_base;
                    mem_plane_d = PL_Y;
                    burst_d     = '0;
                end
            end
            FETCH_Y: begin
                if (mem_ack_i) begin
                    if (vs_abort) begin
                        state_d   = IDLE;
                        mem_req_d = 1'b0;
                    end else if (burst_q != Y_LAST) begin
                        burst_d   = burst_q + BW'(1);
                        mem_adr_d = mem_adr_q + STEP;
                    end else if (!line_q[0]) begin
                        state_d     = FETCH_U;
                        burst_d     = '0;
                        mem_adr_d   = u_base;
                        mem_plane_d = PL_U;
                    end else begin
                        state_d   = DONE;
                        mem_req_d = 1'b0;
                    end
                end
            end
            FETCH_U: begin
                if (mem_ack_i) begin
                    if (vs_abort) begin
                        state_d   = IDLE;
                        mem_req_d = 1'b0;
                    end else if (burst_q != C_LAST) begin
                        burst_d   = burst_q + BW'(1);
                        mem_adr_d = mem_adr_q + STEP;
                    end else begin
                        state_d     = FETCH_V;
                        burst_d     = '0;
                        mem_adr_d   = v_base;
                        mem_plane_d = PL_V;
                    end
                end
            end
            FETCH_V: begin
                if (mem_ack_i) begin
                    if (vs_abort) begin
                        state_d   = IDLE;
                        mem_req_d = 1'b0;
                    end else if (burst_q != C_LAST) begin
                        burst_d   = burst_q + BW'(1);
                        mem_adr_d = mem_adr_q + STEP;
                    end else begin
                        state_d   = DONE;
                        mem_req_d = 1'b0;
                    end
                end
            end
            DONE: begin
                line_d  = line_q + LW'(1);
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q       <= IDLE;
            cur_y_q       <= '0;
            cur_u_q       <= '0;
            cur_v_q       <= '0;
            line_q        <= '0;
            pending_vs_q  <= 1'b0;
            has_frame_q   <= 1'b0;
            repeat_cnt_q  <= 8'd0;
            overrun_q     <= 1'b0;
            burst_q       <= '0;
            mem_req_q     <= 1'b0;
            mem_adr_q     <= '0;
            mem_plane_q   <= 2'd0;
            release_q     <= 1'b0;
            released_y_q  <= '0;
            released_u_q  <= '0;
            released_v_q  <= '0;
            strobe_prev_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_y_q       <= cur_y_d;
            cur_u_q       <= cur_u_d;
            cur_v_q       <= cur_v_d;
            line_q        <= line_d;
            pending_vs_q  <= pending_vs_d;
            has_frame_q   <= has_frame_d;
            repeat_cnt_q  <= repeat_cnt_d;
            overrun_q     <= overrun_d;
            burst_q       <= burst_d;
            mem_req_q     <= mem_req_d;
            mem_adr_q     <= mem_adr_d;
            mem_plane_q   <= mem_plane_d;
            release_q     <= release_d;
            released_y_q  <= released_y_d;
            released_u_q  <= released_u_d;
            released_v_q  <= released_v_d;
            strobe_prev_q <= fifo_strobe_o;
        end
    end

    assign mem_req_o    = mem_req_q;
    assign mem_adr_o    = mem_adr_q;
    assign mem_plane_o  = mem_plane_q;
    assign line_done_o  = (state_q == DONE);
    assign release_o    = release_q;
    assign released_y_o = released_y_q;
    assign released_u_o = released_u_q;
    assign released_v_o = released_v_q;
    assign has_frame_o  = has_frame_q;
    assign repeat_cnt_o = repeat_cnt_q;
    assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_yuv_frame_scanout_sched.sv
// tb/tb_yuv_frame_scanout_sched.sv - directed bench with a transaction-level scan-out model
module tb_yuv_frame_scanout_sched;
    localparam int WIDTH  = 64;
    localparam int HEIGHT = 4;
    localparam int BURST  = 16;
    localparam int ADR_W  = 24;
    localparam int DESC_W = 32;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              fifo_valid;
    logic [DESC_W-1:0] fifo_y, fifo_u, fifo_v;
    logic              fifo_strobe;
    logic              vsync, line_req;
    logic              mem_req;
    logic [ADR_W-1:0]  mem_adr;
    logic [1:0]        mem_plane;
    logic              mem_ack;
    logic              line_done, release_p;
    logic [DESC_W-1:0] rel_y, rel_u, rel_v;
    logic              has_frame;
    logic [7:0]        repeat_cnt;
    logic              overrun;

    always #5 clk = ~clk;

    yuv_frame_scanout_sched #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .BURST(BURST), .ADR_W(ADR_W), .DESC_W(DESC_W)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .fifo_valid_i(fifo_valid), .fifo_y_i(fifo_y), .fifo_u_i(fifo_u), .fifo_v_i(fifo_v),
        .fifo_strobe_o(fifo_strobe), .vsync_i(vsync), .line_req_i(line_req),
        .mem_req_o(mem_req), .mem_adr_o(mem_adr), .mem_plane_o(mem_plane), .mem_ack_i(mem_ack),
        .line_done_o(line_done), .release_o(release_p),
        .released_y_o(rel_y), .released_u_o(rel_u), .released_v_o(rel_v),
        .has_frame_o(has_frame), .repeat_cnt_o(repeat_cnt), .overrun_o(overrun)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model: what the display should have fetched, popped and retired so far.
    logic [DESC_W-1:0] m_y = '0, m_u = '0, m_v = '0;
    bit                m_has = 0, m_over = 0;
    int                m_line = 0, m_rep = 0, m_strobe = 0, m_done = 0;
    logic [25:0]       exp_q[$];
    logic [95:0]       exp_rel[$];

    int                n_strobe = 0, n_done = 0, done_cyc = 0;
    bit                prev_strobe = 0;
    logic [ADR_W-1:0]  obs_adr[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_vsync(input bit valid, input logic [DESC_W-1:0] y,
                                        input logic [DESC_W-1:0] u, input logic [DESC_W-1:0] v);
        if (valid) begin
            if (m_has) exp_rel.push_back({m_y, m_u, m_v});
            m_y = y; m_u = u; m_v = v;
            m_has = 1; m_rep = 0; m_strobe++;
        end else if (m_has && m_rep < 255) begin
            m_rep++;
        end
        m_line = 0;
    endfunction

    function automatic void model_line();
        logic [ADR_W-1:0] a;
        for (int k = 0; k < WIDTH / BURST; k++) begin
            a = ADR_W'(m_y + m_line * WIDTH + k * BURST);
            exp_q.push_back({2'd0, a});
        end
        if (m_line % 2 == 0) begin
            for (int k = 0; k < WIDTH / (2 * BURST); k++) begin
                a = ADR_W'(m_u + (m_line / 2) * (WIDTH / 2) + k * BURST);
                exp_q.push_back({2'd1, a});
            end
            for (int k = 0; k < WIDTH / (2 * BURST); k++) begin
                a = ADR_W'(m_v + (m_line / 2) * (WIDTH / 2) + k * BURST);
                exp_q.push_back({2'd2, a});
            end
        end
        m_done++;
        m_line++;
    endfunction

    always @(negedge clk) begin
        if (reset_n) begin
            if (mem_req && mem_ack) begin
                logic [25:0] e;
                obs_adr.push_back(mem_adr);
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL burst_unexpected: got adr %0h plane %0d, none expected", mem_adr, mem_plane);
                end else begin
                    e = exp_q.pop_front();
                    chk("burst", {6'd0, mem_plane, mem_adr}, {6'd0, e});
                end
            end
            if (release_p) begin
                logic [95:0] r;
                if (exp_rel.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL release_unexpected: got y %0h, none expected", rel_y);
                end else begin
                    r = exp_rel.pop_front();
                    chk("released_y", rel_y, r[95:64]);
                    chk("released_u", rel_u, r[63:32]);
                    chk("released_v", rel_v, r[31:0]);
                end
            end
            if (fifo_strobe) begin
                n_strobe++;
                chk("strobe_gap", {31'd0, prev_strobe}, 32'd0);
                chk("strobe_valid", {31'd0, fifo_valid}, 32'd1);
            end
            if (line_done) begin
                n_done++;
                done_cyc = cyc;
            end
            prev_strobe = fifo_strobe;
        end
    end

    task automatic check_state(input string tag);
        @(negedge clk);
        chk({tag, "_has_frame"}, {31'd0, has_frame}, {31'd0, m_has});
        chk({tag, "_repeat_cnt"}, {24'd0, repeat_cnt}, 32'(m_rep));
        chk({tag, "_overrun"}, {31'd0, overrun}, {31'd0, m_over});
        chk({tag, "_strobes"}, 32'(n_strobe), 32'(m_strobe));
        chk({tag, "_line_dones"}, 32'(n_done), 32'(m_done));
        chk({tag, "_bursts_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_vsync(input bit valid, input logic [DESC_W-1:0] y, input logic [DESC_W-1:0] u,
                            input logic [DESC_W-1:0] v, input bit with_line, input string tag);
        @(posedge clk); #1;
        vsync = 1; line_req = with_line;
        fifo_valid = valid; fifo_y = y; fifo_u = u; fifo_v = v;
        model_vsync(valid, y, u, v);
        @(posedge clk); #1;
        vsync = 0; line_req = 0;
        @(posedge clk); #1;
        fifo_valid = 0;
        repeat (2) @(posedge clk);
        check_state(tag);
    endtask

    task automatic do_line(input bit extra, input int exp_lat, input string tag);
        bit accept;
        int t0;
        accept = m_has && (m_line < HEIGHT);
        @(posedge clk); #1;
        line_req = 1;
        t0 = cyc;
        if (accept) model_line();
        @(posedge clk); #1;
        line_req = 0;
        if (extra) begin
            @(posedge clk); #1;
            line_req = 1;
            m_over = 1;
            @(posedge clk); #1;
            line_req = 0;
        end
        if (accept) begin
            for (int i = 0; i < 60 && n_done != m_done; i++) @(negedge clk);
            chk({tag, "_done_seen"}, 32'(n_done), 32'(m_done));
            if (exp_lat > 0) chk({tag, "_latency"}, 32'(done_cyc - t0 + 1), 32'(exp_lat));
        end else begin
            repeat (10) @(negedge clk);
        end
        repeat (2) @(posedge clk);
        check_state(tag);
    endtask

    localparam logic [31:0] A_Y = 32'h1000, A_U = 32'h2000, A_V = 32'h2800;
    localparam logic [31:0] B_Y = 32'h3000, B_U = 32'h4000, B_V = 32'h4800;

    logic [ADR_W-1:0] lit_adr[20] = '{
        24'h1000, 24'h1010, 24'h1020, 24'h1030, 24'h2000, 24'h2010, 24'h2800, 24'h2810,
        24'h1040, 24'h1050, 24'h1060, 24'h1070,
        24'h1080, 24'h1090, 24'h10A0, 24'h10B0, 24'h2020, 24'h2030, 24'h2820, 24'h2830
    };

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        reset_n = 0; fifo_valid = 0; fifo_y = '0; fifo_u = '0; fifo_v = '0;
        vsync = 0; line_req = 0; mem_ack = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_adr", {8'd0, mem_adr}, 32'd0);
        chk("rst_strobe", {31'd0, fifo_strobe}, 32'd0);
        chk("rst_line_done", {31'd0, line_done}, 32'd0);
        chk("rst_release", {31'd0, release_p}, 32'd0);
        chk("rst_released_y", rel_y, 32'd0);
        chk("rst_has_frame", {31'd0, has_frame}, 32'd0);
        chk("rst_repeat", {24'd0, repeat_cnt}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        @(posedge clk); #1;
        reset_n = 1;

        do_line(0, 0, "noframe");
        do_vsync(1, A_Y, A_U, A_V, 0, "vsA");
        chk("vsA_repeat_lit", {24'd0, repeat_cnt}, 32'd0);

        do_line(0, 10, "A_l0");
        do_line(0, 6, "A_l1");
        do_line(0, 10, "A_l2");
        for (int i = 0; i < 20; i++) chk("lit_adr", {8'd0, obs_adr[i]}, {8'd0, lit_adr[i]});
        do_line(0, 6, "A_l3");
        do_line(0, 0, "A_fifth");

        do_vsync(0, '0, '0, '0, 0, "rep1");
        chk("rep1_lit", {24'd0, repeat_cnt}, 32'd1);
        idx = obs_adr.size();
        do_line(0, 10, "A_again");
        chk("restart_lit", {8'd0, obs_adr[idx]}, 32'h1000);

        do_vsync(0, '0, '0, '0, 1, "vs_line_same");
        chk("rep2_lit", {24'd0, repeat_cnt}, 32'd2);

        // Stall the second Y burst of line 0 and pulse vsync with B during the stall.
        @(posedge clk); #1;
        line_req = 1;
        exp_q.push_back({2'd0, ADR_W'(m_y)});
        exp_q.push_back({2'd0, ADR_W'(m_y + BURST)});
        @(posedge clk); #1;
        line_req = 0;
        @(posedge clk); #1;
        mem_ack = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_adr", {8'd0, mem_adr}, 32'h1010);
            chk("stall_req", {31'd0, mem_req}, 32'd1);
            @(posedge clk); #1;
            if (i == 1) begin
                vsync = 1; fifo_valid = 1; fifo_y = B_Y; fifo_u = B_U; fifo_v = B_V;
                model_vsync(1, B_Y, B_U, B_V);
            end
            if (i == 2) vsync = 0;
            if (i == 4) mem_ack = 1;
        end
        repeat (10) @(posedge clk); #1;
        fifo_valid = 0;
        repeat (2) @(posedge clk);
        check_state("stall");
        chk("stall_repeat_lit", {24'd0, repeat_cnt}, 32'd0);

        idx = obs_adr.size();
        do_line(0, 10, "B_l0");
        chk("B_first_lit", {8'd0, obs_adr[idx]}, 32'h3000);
        do_line(1, 6, "B_l1_overrun");
        chk("overrun_lit", {31'd0, overrun}, 32'd1);
        do_line(0, 10, "B_l2");
        chk("overrun_sticky", {31'd0, overrun}, 32'd1);
        chk("release_left", 32'(exp_rel.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
